// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: sequences FETCH/DECODE/EXEC/MEM/WB/BRANCH,
// waits on a memory handshake with a bounded timeout, and counts retired instructions.
module multicycle_control #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        halted,
    output logic        error,
    output logic [2:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        BRANCH = 3'd6,
        HALT   = 3'd7
    } stateT;

    typedef enum logic [3:0] {
        OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI,
        OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_BAD
    } opClassT;

    // Last wait-counter value before a still-pending access gives up.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    stateT       curState;
    opClassT     curClass;
    opClassT     decClass;
    logic [7:0]  waitCount;
    logic [31:0] instrCount;
    logic        errorReg;
    logic        timedOut;
    logic        taken;
    logic        retire;
    stateT       afterRetire;

    // Classify the opcode currently presented by the instruction register.
    always_comb begin
        decClass = OP_BAD;
        case (opcode)
            6'h00:   decClass = OP_R;
            6'h08:   decClass = OP_ADDI;
            6'h0C:   decClass = OP_ANDI;
            6'h0D:   decClass = OP_ORI;
            6'h0F:   decClass = OP_LUI;
            6'h23:   decClass = OP_LW;
            6'h2B:   decClass = OP_SW;
            6'h04:   decClass = OP_BEQ;
            6'h05:   decClass = OP_BNE;
            6'h02:   decClass = OP_J;
            default: decClass = OP_BAD;
        endcase
    end

    // Shared conditions: access timeout, branch outcome and retirement point.
    always_comb begin
        timedOut    = !mem_ready && (waitCount == WAIT_LIMIT);
        taken       = ((curClass == OP_BEQ) && zero) || ((curClass == OP_BNE) && !zero);
        retire      = ((curState == DECODE) && (decClass == OP_J)) ||
                      ((curState == MEM) && mem_ready && (curClass == OP_SW)) ||
                      (curState == WB) || (curState == BRANCH);
        afterRetire = run ? FETCH : IDLE;
    end

    // State sequencing, wait counting, retirement count and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            curState   <= IDLE;
            curClass   <= OP_R;
            waitCount  <= '0;
            instrCount <= '0;
            errorReg   <= 1'b0;
        end else begin
            waitCount <= '0;
            if (retire) begin
                instrCount <= instrCount + 32'd1;
            end
            case (curState)
                IDLE: begin
                    if (run) curState <= FETCH;
                end
                FETCH: begin
                    if (mem_ready) begin
                        curState <= DECODE;
                    end else if (timedOut) begin
                        curState <= HALT;
                        errorReg <= 1'b1;
                    end else begin
                        waitCount <= waitCount + 8'd1;
                    end
                end
                DECODE: begin
                    curClass <= decClass;
                    case (decClass)
                        OP_BAD: begin
                            curState <= HALT;
                            errorReg <= 1'b1;
                        end
                        OP_J:           curState <= afterRetire;
                        OP_BEQ, OP_BNE: curState <= BRANCH;
                        default:        curState <= EXEC;
                    endcase
                end
                EXEC: begin
                    if (curClass == OP_LW || curClass == OP_SW) curState <= MEM;
                    else                                        curState <= WB;
                end
                MEM: begin
                    if (mem_ready) begin
                        curState <= (curClass == OP_SW) ? afterRetire : WB;
                    end else if (timedOut) begin
                        curState <= HALT;
                        errorReg <= 1'b1;
                    end else begin
                        waitCount <= waitCount + 8'd1;
                    end
                end
                WB:      curState <= afterRetire;
                BRANCH:  curState <= afterRetire;
                HALT:    curState <= HALT;
                default: curState <= IDLE;
            endcase
        end
    end

    // Control outputs; strobes react to mem_ready within the completing cycle.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        case (curState)
            FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            DECODE: begin
                if (decClass == OP_J) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                end
            end
            EXEC: begin
                case (curClass)
                    OP_R:    begin alu_src = 1'b0; alu_op = 3'b111; end
                    OP_ANDI: begin alu_src = 1'b1; alu_op = 3'b011; end
                    OP_ORI:  begin alu_src = 1'b1; alu_op = 3'b010; end
                    OP_LUI:  begin alu_src = 1'b1; alu_op = 3'b100; end
                    default: begin alu_src = 1'b1; alu_op = 3'b000; end
                endcase
            end
            MEM: begin
                iord      = 1'b1;
                alu_src   = 1'b1;
                mem_read  = (curClass == OP_LW);
                mem_write = (curClass == OP_SW);
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = (curClass == OP_R);
                mem_to_reg = (curClass == OP_LW);
            end
            BRANCH: begin
                alu_op = 3'b001;
                if (taken) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b01;
                end
            end
            default: begin
            end
        endcase
    end

    assign halted      = (curState == HALT);
    assign error       = errorReg;
    assign state       = curState;
    assign instr_count = instrCount;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: per-instruction expected traces derived
// from the instruction-class rules, driven with randomized don't-care inputs.
module tb_multicycle_control;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset, run, zero, mem_ready;
    logic [5:0]  opcode;
    logic        pc_write, ir_write, iord, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, alu_src, halted, error;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op, state;
    logic [31:0] instr_count;
    logic [18:0] obsVec;

    typedef struct packed {
        logic [18:0] exp;
        logic [31:0] cnt;
        logic        ready;
        logic        zeroIn;
        logic        runIn;
        logic [5:0]  opIn;
    } recT;

    recT         expQ[$];
    logic [18:0] obsQ[$];
    logic [31:0] cntQ[$];
    logic [31:0] expCount;
    int          checks = 0;
    int          errors = 0;

    multicycle_control #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
        .halted(halted), .error(error), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign obsVec = {state, pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                     reg_write, reg_dst, mem_to_reg, alu_src, alu_op, halted, error};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [18:0] mkVec(input logic [2:0] st, input logic pcw,
            input logic [1:0] pcs, input logic irw, input logic ad, input logic mr,
            input logic mw, input logic rw, input logic rd, input logic m2r,
            input logic as, input logic [2:0] aop, input logic h, input logic e);
        return {st, pcw, pcs, irw, ad, mr, mw, rw, rd, m2r, as, aop, h, e};
    endfunction

    task automatic pushRec(input logic [18:0] v, input logic rdy, input logic z,
                           input logic r, input logic [5:0] op, input logic ret);
        recT rec;
        rec.exp = v; rec.cnt = expCount; rec.ready = rdy;
        rec.zeroIn = z; rec.runIn = r; rec.opIn = op;
        expQ.push_back(rec);
        if (ret) expCount = expCount + 32'd1;
    endtask

    task automatic pushIdle(input logic r);
        pushRec(mkVec(3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      1'b0, 3'b000, 1'b0, 1'b0), rb(), rb(), r, 6'($urandom), 1'b0);
    endtask

    task automatic pushHalt(input int n);
        for (int i = 0; i < n; i++)
            pushRec(mkVec(3'd7, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0, 3'b000, 1'b1, 1'b1), rb(), rb(), rb(), 6'($urandom), 1'b0);
    endtask

    // Reference model: expected per-cycle behaviour of one instruction.
    task automatic buildInstr(input logic [5:0] op, input logic z, input int fetchWait,
                              input int memWait, input logic runEnd);
        logic isR, isLw, isSw, legal, tk, rdy, aSrc;
        logic [2:0] aOp;
        isR   = (op == 6'h00);
        isLw  = (op == 6'h23);
        isSw  = (op == 6'h2B);
        legal = op inside {6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        for (int i = 0; i <= fetchWait && i < TIMEOUT; i++) begin
            rdy = (i == fetchWait);
            pushRec(mkVec(3'd1, rdy, 2'b00, rdy, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0, 3'b000, 1'b0, 1'b0), rdy, rb(), rb(), op, 1'b0);
        end
        if (fetchWait >= TIMEOUT) begin
            pushHalt(4);
            return;
        end
        if (op == 6'h02) begin
            pushRec(mkVec(3'd2, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0, 3'b000, 1'b0, 1'b0), rb(), rb(), runEnd, op, 1'b1);
            return;
        end
        pushRec(mkVec(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      1'b0, 3'b000, 1'b0, 1'b0), rb(), rb(), rb(), op, 1'b0);
        if (!legal) begin
            pushHalt(6);
            return;
        end
        if (op == 6'h04 || op == 6'h05) begin
            tk = (op == 6'h04) ? z : !z;
            pushRec(mkVec(3'd6, tk, tk ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0), rb(), z, runEnd, op, 1'b1);
            return;
        end
        case (op)
            6'h00:   begin aSrc = 1'b0; aOp = 3'b111; end
            6'h0C:   begin aSrc = 1'b1; aOp = 3'b011; end
            6'h0D:   begin aSrc = 1'b1; aOp = 3'b010; end
            6'h0F:   begin aSrc = 1'b1; aOp = 3'b100; end
            default: begin aSrc = 1'b1; aOp = 3'b000; end
        endcase
        pushRec(mkVec(3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      aSrc, aOp, 1'b0, 1'b0), rb(), rb(), rb(), op, 1'b0);
        if (isLw || isSw) begin
            for (int i = 0; i <= memWait; i++) begin
                rdy = (i == memWait);
                pushRec(mkVec(3'd4, 1'b0, 2'b00, 1'b0, 1'b1, isLw, isSw, 1'b0, 1'b0, 1'b0,
                              1'b1, 3'b000, 1'b0, 1'b0), rdy, rb(),
                        (isSw && rdy) ? runEnd : rb(), op, isSw && rdy);
            end
            if (isSw) return;
        end
        pushRec(mkVec(3'd5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, isR, isLw,
                      1'b0, 3'b000, 1'b0, 1'b0), rb(), rb(), runEnd, op, 1'b1);
    endtask

    // Drive the expected-trace inputs cycle by cycle and record DUT outputs.
    task automatic runTrace();
        obsQ.delete();
        cntQ.delete();
        foreach (expQ[i]) begin
            @(negedge clk);
            mem_ready = expQ[i].ready;
            zero      = expQ[i].zeroIn;
            run       = expQ[i].runIn;
            opcode    = expQ[i].opIn;
            #1;
            obsQ.push_back(obsVec);
            cntQ.push_back(instr_count);
        end
    endtask

    task automatic applyStimulusReset();
        @(negedge clk);
        reset = 1'b1; run = rb(); mem_ready = rb(); zero = rb(); opcode = 6'($urandom);
        @(negedge clk);
        run = rb(); mem_ready = rb();
        @(negedge clk);
        reset = 1'b0; run = 1'b0; mem_ready = 1'b0;
        expCount = 32'd0;
        #1;
    endtask

    task automatic test_reset();
        applyStimulusReset();
        checks++;
        if (obsVec !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obsVec, 19'd0);
        end
        checks++;
        if (instr_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %h expected %h", instr_count, 32'd0);
        end
    endtask

    task automatic test_addi();
        int rwPulses;
        expQ.delete();
        pushIdle(1'b1);
        buildInstr(6'h08, 1'b0, 0, 0, 1'b1);
        buildInstr(6'h04, 1'b0, 1, 0, 1'b0);
        pushIdle(1'b0);
        runTrace();
        rwPulses = 0;
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i].exp || cntQ[i] !== expQ[i].cnt) begin
                errors++;
                $display("[TB] FAIL addi cycle %0d: ctrl=%h count=%h, expected ctrl=%h count=%h",
                         i, obsQ[i], cntQ[i], expQ[i].exp, expQ[i].cnt);
            end
            if (obsQ[i][8]) rwPulses++;
        end
        checks++;
        if (rwPulses !== 1) begin
            errors++;
            $display("[TB] FAIL addi_reg_write_pulses: got %0d expected 1", rwPulses);
        end
    endtask

    task automatic test_lw();
        int memCycles;
        expQ.delete();
        pushIdle(1'b1);
        buildInstr(6'h23, rb(), 2, 3, 1'b0);
        pushIdle(1'b0);
        runTrace();
        memCycles = 0;
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i].exp || cntQ[i] !== expQ[i].cnt) begin
                errors++;
                $display("[TB] FAIL lw cycle %0d: ctrl=%h count=%h, expected ctrl=%h count=%h",
                         i, obsQ[i], cntQ[i], expQ[i].exp, expQ[i].cnt);
            end
            if (obsQ[i][11] && obsQ[i][10]) memCycles++;
        end
        checks++;
        if (memCycles !== 4) begin
            errors++;
            $display("[TB] FAIL lw_mem_hold: got %0d cycles expected 4", memCycles);
        end
    endtask

    task automatic test_branch();
        expQ.delete();
        pushIdle(1'b1);
        buildInstr(6'h04, 1'b1, 0, 0, 1'b1);
        buildInstr(6'h05, 1'b1, 1, 0, 1'b1);
        buildInstr(6'h02, 1'b0, 0, 0, 1'b0);
        pushIdle(1'b0);
        runTrace();
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i].exp || cntQ[i] !== expQ[i].cnt) begin
                errors++;
                $display("[TB] FAIL branch cycle %0d: ctrl=%h count=%h, expected ctrl=%h count=%h",
                         i, obsQ[i], cntQ[i], expQ[i].exp, expQ[i].cnt);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] legalOps [10] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F,
                                      6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        logic runEnd;
        int fw, mw, idles;
        expQ.delete();
        pushIdle(1'b1);
        for (int n = 0; n < 40; n++) begin
            fw = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 4));
            mw = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 4));
            runEnd = (n == 39) ? 1'b0 : ($urandom_range(0, 3) != 0);
            buildInstr(legalOps[$urandom_range(0, 9)], rb(), fw, mw, runEnd);
            if (!runEnd && n != 39) begin
                idles = int'($urandom_range(0, 2));
                for (int k = 0; k < idles; k++) pushIdle(1'b0);
                pushIdle(1'b1);
            end
        end
        pushIdle(1'b0);
        runTrace();
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i].exp || cntQ[i] !== expQ[i].cnt) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: ctrl=%h count=%h, expected ctrl=%h count=%h",
                         i, obsQ[i], cntQ[i], expQ[i].exp, expQ[i].cnt);
            end
        end
    endtask

    task automatic test_illegal();
        expQ.delete();
        pushIdle(1'b1);
        buildInstr(6'h3F, rb(), 0, 0, 1'b1);
        runTrace();
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i].exp || cntQ[i] !== expQ[i].cnt) begin
                errors++;
                $display("[TB] FAIL illegal cycle %0d: ctrl=%h count=%h, expected ctrl=%h count=%h",
                         i, obsQ[i], cntQ[i], expQ[i].exp, expQ[i].cnt);
            end
        end
        applyStimulusReset();
        checks++;
        if (obsVec !== 19'd0 || instr_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL illegal_reset: ctrl=%h count=%h expected ctrl=0 count=0",
                     obsVec, instr_count);
        end
    endtask

    task automatic test_timeout();
        expQ.delete();
        pushIdle(1'b1);
        buildInstr(6'h08, rb(), TIMEOUT, 0, 1'b1);
        runTrace();
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i].exp || cntQ[i] !== expQ[i].cnt) begin
                errors++;
                $display("[TB] FAIL timeout cycle %0d: ctrl=%h count=%h, expected ctrl=%h count=%h",
                         i, obsQ[i], cntQ[i], expQ[i].exp, expQ[i].cnt);
            end
        end
        applyStimulusReset();
        expQ.delete();
        pushIdle(1'b1);
        buildInstr(6'h0D, rb(), TIMEOUT - 1, 0, 1'b0);
        pushIdle(1'b0);
        runTrace();
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i].exp || cntQ[i] !== expQ[i].cnt) begin
                errors++;
                $display("[TB] FAIL late_ready cycle %0d: ctrl=%h count=%h, expected ctrl=%h count=%h",
                         i, obsQ[i], cntQ[i], expQ[i].exp, expQ[i].cnt);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        expQ.delete();
        pushIdle(1'b1);
        buildInstr(6'h2B, rb(), 0, 10, 1'b1);
        while (expQ.size() > 7) void'(expQ.pop_back());
        runTrace();
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i].exp || cntQ[i] !== expQ[i].cnt) begin
                errors++;
                $display("[TB] FAIL sw_wait cycle %0d: ctrl=%h count=%h, expected ctrl=%h count=%h",
                         i, obsQ[i], cntQ[i], expQ[i].exp, expQ[i].cnt);
            end
        end
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0; run = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b1 || iord !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_before: mem_write=%b iord=%b expected 1 1", mem_write, iord);
        end
        @(negedge clk);
        reset = 1'b0; run = 1'b0; mem_ready = 1'b1;
        expCount = 32'd0;
        #1;
        checks++;
        if (obsVec !== 19'd0 || instr_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_after: ctrl=%h count=%h expected ctrl=0 count=0",
                     obsVec, instr_count);
        end
    endtask

    task automatic test_wrap();
        force dut.instrCount = 32'hFFFF_FFFF;
        #1;
        release dut.instrCount;
        expCount = 32'hFFFF_FFFF;
        expQ.delete();
        pushIdle(1'b1);
        buildInstr(6'h00, rb(), 1, 0, 1'b1);
        buildInstr(6'h2B, rb(), 0, 2, 1'b0);
        pushIdle(1'b0);
        pushIdle(1'b0);
        runTrace();
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i].exp || cntQ[i] !== expQ[i].cnt) begin
                errors++;
                $display("[TB] FAIL wrap cycle %0d: ctrl=%h count=%h, expected ctrl=%h count=%h",
                         i, obsQ[i], cntQ[i], expQ[i].exp, expQ[i].cnt);
            end
        end
        checks++;
        if (instr_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL wrap_final: got %h expected %h", instr_count, 32'd1);
        end
    endtask

    // Safety net so the run always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        reset = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
        expCount = 32'd0;
        test_reset();
        test_addi();
        test_lw();
        test_branch();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_mid_access();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
